// File: rtl/sdram_ext_arbiter.sv
// sdram_ext_arbiter
//   Two-port round-robin arbiter in front of the SDRAM controller's single-word
//   external access port. Port A (CPU bridge) and port B (blitter/DMA) each
//   hold a level request until their one-cycle Ack. The winner's fields are
//   latched onto the Ext* outputs at grant. The ExtReq/ExtReady handshake runs
//   through ISSUE (waiting for the controller to accept) and WAIT (waiting for
//   it to finish). Read data is captured into the granted port's RData.
//   Only one transaction is ever outstanding.
//
// Ports:
//   PixelClk2            system clock, rising edge
//   nReset               asynchronous active-low reset
//   ReqA/ReqB            level requests, held until the matching Ack
//   OpA/OpB              0 = read, 1 = write
//   AddrA/AddrB          word address (ADDR_W)
//   WDataA/WDataB        write data (DATA_W)
//   MaskA/MaskB          DQM byte mask, 1 = byte masked
//   RDataA/RDataB        read data, valid in and after the Ack cycle
//   AckA/AckB            one-cycle completion pulse (registered)
//   ExtReq               request to the SDRAM controller
//   ExtOP/ExtAddr/ExtDataWrite/ExtDataMask   latched request fields
//   ExtDataRead          read data from the controller
//   ExtReady             controller idle/accept flag (changes on falling edge)
//   Busy                 high whenever a transaction is in progress
module sdram_ext_arbiter #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
) (
    input  logic              PixelClk2,
    input  logic              nReset,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              OpA,
    input  logic              OpB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WDataA,
    input  logic [DATA_W-1:0] WDataB,
    input  logic [1:0]        MaskA,
    input  logic [1:0]        MaskB,
    output logic [DATA_W-1:0] RDataA,
    output logic [DATA_W-1:0] RDataB,
    output logic              AckA,
    output logic              AckB,
    output logic              ExtReq,
    output logic              ExtOP,
    output logic [ADDR_W-1:0] ExtAddr,
    output logic [DATA_W-1:0] ExtDataWrite,
    output logic [1:0]        ExtDataMask,
    input  logic [DATA_W-1:0] ExtDataRead,
    input  logic              ExtReady,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              nextState_s;

    // Port of the most recent grant (1 = B). It doubles as the granted port of
    // the transaction in flight, because LastGrant is set to the winner at grant.
    logic                lastGrantB_r;

    logic                winB_s;
    logic                opSel_s;
    logic [ADDR_W-1:0]   addrSel_s;
    logic [DATA_W-1:0]   wdataSel_s;
    logic [1:0]          maskSel_s;

    logic                grantNow_s;
    logic                completeNow_s;
    logic                extReq_s;
    logic                busy_s;
    logic                ackA_s;
    logic                ackB_s;
    logic                loadA_s;
    logic                loadB_s;

    // Round-robin winner: a sole requester wins, a tie goes to the port not granted last.
    always_comb begin
        winB_s = 1'b0;
        if (ReqA && ReqB) begin
            winB_s = ~lastGrantB_r;
        end else if (ReqB) begin
            winB_s = 1'b1;
        end else begin
            winB_s = 1'b0;
        end
    end

    // Select the winner's request fields for latching at grant.
    always_comb begin
        opSel_s    = OpA;
        addrSel_s  = AddrA;
        wdataSel_s = WDataA;
        maskSel_s  = MaskA;
        if (winB_s) begin
            opSel_s    = OpB;
            addrSel_s  = AddrB;
            wdataSel_s = WDataB;
            maskSel_s  = MaskB;
        end else begin
            opSel_s    = OpA;
            addrSel_s  = AddrA;
            wdataSel_s = WDataA;
            maskSel_s  = MaskA;
        end
    end

    // FSM state register.
    always_ff @(posedge PixelClk2 or negedge nReset) begin
        if (!nReset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic. No timeout in ISSUE: refresh and video fills may
    // keep the controller from accepting for an arbitrary time.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (ExtReady && (ReqA || ReqB)) begin
                    nextState_s = ISSUE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            ISSUE: begin
                if (!ExtReady) begin
                    nextState_s = WAIT;
                end else begin
                    nextState_s = ISSUE;
                end
            end
            WAIT: begin
                if (ExtReady) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DONE: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // FSM output decode: next values of the registered outputs.
    // Ack is raised on the edge entering DONE, so it is high for exactly the DONE cycle.
    always_comb begin
        grantNow_s    = 1'b0;
        completeNow_s = 1'b0;
        extReq_s      = 1'b0;
        busy_s        = 1'b0;
        ackA_s        = 1'b0;
        ackB_s        = 1'b0;
        loadA_s       = 1'b0;
        loadB_s       = 1'b0;
        if ((state_r == IDLE) && (nextState_s == ISSUE)) begin
            grantNow_s = 1'b1;
        end else begin
            grantNow_s = 1'b0;
        end
        if ((state_r == WAIT) && ExtReady) begin
            completeNow_s = 1'b1;
        end else begin
            completeNow_s = 1'b0;
        end
        extReq_s = (nextState_s == ISSUE);
        busy_s   = (nextState_s != IDLE);
        ackA_s   = completeNow_s && !lastGrantB_r;
        ackB_s   = completeNow_s &&  lastGrantB_r;
        // Writes never touch RData.
        loadA_s  = ackA_s && !ExtOP;
        loadB_s  = ackB_s && !ExtOP;
    end

    // Registered outputs, grant latch and read-data capture.
    always_ff @(posedge PixelClk2 or negedge nReset) begin
        if (!nReset) begin
            ExtReq       <= 1'b0;
            Busy         <= 1'b0;
            AckA         <= 1'b0;
            AckB         <= 1'b0;
            ExtOP        <= 1'b0;
            ExtAddr      <= {ADDR_W{1'b0}};
            ExtDataWrite <= {DATA_W{1'b0}};
            ExtDataMask  <= 2'b00;
            RDataA       <= {DATA_W{1'b0}};
            RDataB       <= {DATA_W{1'b0}};
            lastGrantB_r <= 1'b1;
        end else begin
            ExtReq <= extReq_s;
            Busy   <= busy_s;
            AckA   <= ackA_s;
            AckB   <= ackB_s;
            if (grantNow_s) begin
                ExtOP        <= opSel_s;
                ExtAddr      <= addrSel_s;
                ExtDataWrite <= wdataSel_s;
                ExtDataMask  <= maskSel_s;
                lastGrantB_r <= winB_s;
            end
            if (loadA_s) begin
                RDataA <= ExtDataRead;
            end
            if (loadB_s) begin
                RDataB <= ExtDataRead;
            end
        end
    end

endmodule

// File: tb/tb_sdram_ext_arbiter.sv
// Testbench for sdram_ext_arbiter: requester agents, an SDRAM controller
// model driving ExtReady on the falling edge, and a transaction-level
// reference model checked against the DUT outputs on every cycle.
module tb_sdram_ext_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    logic              PixelClk2 = 1'b0;
    logic              nReset    = 1'b0;
    logic              ReqA = 1'b0, ReqB = 1'b0, OpA = 1'b0, OpB = 1'b0;
    logic [ADDR_W-1:0] AddrA = '0, AddrB = '0;
    logic [DATA_W-1:0] WDataA = '0, WDataB = '0;
    logic [1:0]        MaskA = 2'b00, MaskB = 2'b00;
    logic [DATA_W-1:0] RDataA, RDataB;
    logic              AckA, AckB, ExtReq, ExtOP, Busy;
    logic [ADDR_W-1:0] ExtAddr;
    logic [DATA_W-1:0] ExtDataWrite;
    logic [1:0]        ExtDataMask;
    logic [DATA_W-1:0] ExtDataRead = '0;
    logic              ExtReady    = 1'b0;

    sdram_ext_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .PixelClk2(PixelClk2), .nReset(nReset),
        .ReqA(ReqA), .ReqB(ReqB), .OpA(OpA), .OpB(OpB),
        .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
        .MaskA(MaskA), .MaskB(MaskB), .RDataA(RDataA), .RDataB(RDataB),
        .AckA(AckA), .AckB(AckB), .ExtReq(ExtReq), .ExtOP(ExtOP),
        .ExtAddr(ExtAddr), .ExtDataWrite(ExtDataWrite), .ExtDataMask(ExtDataMask),
        .ExtDataRead(ExtDataRead), .ExtReady(ExtReady), .Busy(Busy)
    );

    always #6 PixelClk2 = ~PixelClk2;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        mask;
    } txn_t;

    txn_t qA[$], qB[$], ctlLog[$];
    bit   ackLog[$];
    int   ackCntA = 0, ackCntB = 0;
    int   checks = 0, failures = 0;

    bit   presA = 1'b0, presB = 1'b0, randEn = 1'b0;
    bit   ctlForceLow = 1'b1, ctlRandRd = 1'b0;
    int   ctlBusy = 0, ctlHold = 0;
    logic [DATA_W-1:0] ctlRdVal = '0;

    // reference model: one transaction record plus round-robin memory
    bit                mActive = 0, mHanded = 0, mAckNow = 0, mPortB = 0, mLastB = 1;
    logic              mOp = 0;
    logic [ADDR_W-1:0] mAddr = '0;
    logic [DATA_W-1:0] mWData = '0, mRdA = '0, mRdB = '0;
    logic [1:0]        mMask = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t randTxn();
        txn_t t;
        t.op    = 1'($urandom_range(0, 1));
        t.addr  = 24'($urandom());
        t.wdata = 16'($urandom());
        t.mask  = 2'($urandom_range(0, 3));
        return t;
    endfunction

    // main thread works at posedge+3
    task automatic cyc(input int n);
        repeat (n) @(posedge PixelClk2);
        #3;
    endtask

    task automatic waitAck(input bit portB, input int target, input int budget, input string name);
        int n = 0;
        while (((portB ? ackCntB : ackCntA) < target) && (n < budget)) begin
            @(posedge PixelClk2);
            n++;
        end
        #3;
        check(name, 32'(portB ? ackCntB : ackCntA), 32'(target));
    endtask

    // Requester agents: present queued transactions, drop/renew Req on Ack.
    initial begin : agents
        forever begin
            @(posedge PixelClk2);
            #2;
            if (!nReset) begin
                qA.delete(); qB.delete();
                presA = 1'b0; presB = 1'b0; ReqA = 1'b0; ReqB = 1'b0;
            end else begin
                if (AckA) begin
                    ackCntA++; ackLog.push_back(1'b0);
                    if (presA) void'(qA.pop_front());
                    presA = 1'b0;
                end
                if (AckB) begin
                    ackCntB++; ackLog.push_back(1'b1);
                    if (presB) void'(qB.pop_front());
                    presB = 1'b0;
                end
                if (randEn && qA.size() == 0 && $urandom_range(0, 3) == 0) qA.push_back(randTxn());
                if (randEn && qB.size() == 0 && $urandom_range(0, 3) == 0) qB.push_back(randTxn());
                if (!presA) begin
                    if (qA.size() > 0) begin
                        OpA = qA[0].op; AddrA = qA[0].addr; WDataA = qA[0].wdata; MaskA = qA[0].mask;
                        ReqA = 1'b1; presA = 1'b1;
                    end else ReqA = 1'b0;
                end else if (randEn && $urandom_range(0, 2) == 0) begin
                    OpA = 1'($urandom_range(0, 1)); AddrA = 24'($urandom()); WDataA = 16'($urandom());
                end
                if (!presB) begin
                    if (qB.size() > 0) begin
                        OpB = qB[0].op; AddrB = qB[0].addr; WDataB = qB[0].wdata; MaskB = qB[0].mask;
                        ReqB = 1'b1; presB = 1'b1;
                    end else ReqB = 1'b0;
                end else if (randEn && $urandom_range(0, 2) == 0) begin
                    OpB = 1'($urandom_range(0, 1)); AddrB = 24'($urandom()); MaskB = 2'($urandom_range(0, 3));
                end
            end
        end
    end

    // SDRAM controller model: ExtReady changes only on the falling edge.
    initial begin : controller
        forever begin
            @(negedge PixelClk2);
            if (ctlForceLow) begin
                ExtReady = 1'b0;
            end else if (ctlBusy > 0) begin
                ctlBusy--;
                if (ctlBusy == 0) begin
                    ExtDataRead = ctlRdVal;
                    ExtReady    = 1'b1;
                end
            end else if (!ExtReady) begin
                ExtReady = 1'b1;
            end else if (ExtReq) begin
                if (ctlHold > 0) ctlHold--;
                else begin
                    ctlLog.push_back('{ExtOP, ExtAddr, ExtDataWrite, ExtDataMask});
                    ExtReady = 1'b0;
                    if (ctlRandRd) begin
                        ctlRdVal = 16'($urandom());
                        ctlBusy  = $urandom_range(1, 9);
                        ctlHold  = $urandom_range(0, 3);
                    end else begin
                        ctlBusy = ExtOP ? 8 : 7;
                    end
                end
            end
        end
    end

    // Reference model step on each rising edge, then compare all outputs.
    initial begin : compare
        bit sRdy, sReqA, sReqB, winB;
        logic [DATA_W-1:0] sRd;
        forever begin
            @(posedge PixelClk2);
            sRdy = ExtReady; sReqA = ReqA; sReqB = ReqB; sRd = ExtDataRead;
            if (!nReset) begin
                mActive = 0; mHanded = 0; mAckNow = 0; mPortB = 0; mLastB = 1;
                mOp = 0; mAddr = '0; mWData = '0; mMask = 2'b00; mRdA = '0; mRdB = '0;
            end else if (mAckNow) begin
                mAckNow = 0; mActive = 0;          // the Ack cycle ends the transaction
            end else if (!mActive) begin
                if (sRdy && (sReqA || sReqB)) begin
                    winB = (sReqA && sReqB) ? !mLastB : sReqB;
                    mOp    = winB ? OpB : OpA;
                    mAddr  = winB ? AddrB : AddrA;
                    mWData = winB ? WDataB : WDataA;
                    mMask  = winB ? MaskB : MaskA;
                    mPortB = winB; mLastB = winB; mActive = 1; mHanded = 0;
                end
            end else if (!mHanded) begin
                if (!sRdy) mHanded = 1;            // controller took the request
            end else if (sRdy) begin
                if (!mOp) begin
                    if (mPortB) mRdB = sRd; else mRdA = sRd;
                end
                mAckNow = 1;
            end
            #1;
            check("cyc_ExtReq", ExtReq, mActive && !mHanded);
            check("cyc_Busy",   Busy,   mActive);
            check("cyc_AckA",   AckA,   mAckNow && !mPortB);
            check("cyc_AckB",   AckB,   mAckNow && mPortB);
            check("cyc_ExtOP",  ExtOP,  mOp);
            check("cyc_ExtAddr", ExtAddr, mAddr);
            check("cyc_ExtDataWrite", ExtDataWrite, mWData);
            check("cyc_ExtDataMask",  ExtDataMask,  mMask);
            check("cyc_RDataA", RDataA, mRdA);
            check("cyc_RDataB", RDataB, mRdB);
        end
    end

    initial begin : main
        int holdBad, base, n;
        bit expSeq[6];
        txn_t t0, t1;
        expSeq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // reset values
        cyc(3);
        check("rst_ExtReq", ExtReq, 1'b0);
        check("rst_Busy", Busy, 1'b0);
        check("rst_Ack", {AckA, AckB}, 2'b00);
        check("rst_ExtAddr", ExtAddr, 24'h000000);
        check("rst_ExtDataWrite", ExtDataWrite, 16'h0000);
        check("rst_RData", {RDataA, RDataB}, 32'h00000000);
        nReset = 1'b1;

        // init hold: controller not ready, request must not issue
        qA.push_back('{1'b0, 24'h000ABC, 16'h0000, 2'b00});
        holdBad = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (ExtReq !== 1'b0) holdBad++;
        end
        check("init_hold_cycles_with_extreq", 32'(holdBad), 32'd0);
        ctlForceLow = 1'b0;
        cyc(1);
        check("init_release_ExtReq", ExtReq, 1'b1);
        check("init_release_ExtAddr", ExtAddr, 24'h000ABC);
        waitAck(1'b0, 1, 60, "init_ackA");

        // single read A
        ctlRdVal = 16'hBEEF;
        base = ackCntA;
        qA.push_back('{1'b0, 24'h123456, 16'h0000, 2'b00});
        waitAck(1'b0, base + 1, 60, "read_ackA");
        cyc(3);
        check("read_single_ack", 32'(ackCntA), 32'(base + 1));
        check("read_RDataA", RDataA, 16'hBEEF);
        check("read_RDataB_untouched", RDataB, 16'h0000);
        check("read_Busy_idle", Busy, 1'b0);
        t0 = ctlLog[$];
        check("read_ctl_addr", t0.addr, 24'h123456);

        // tie after reset: A wins first
        nReset = 1'b0; cyc(2); nReset = 1'b1; cyc(1);
        ctlLog.delete(); ackLog.delete();
        base = ackCntB;
        qA.push_back('{1'b1, 24'h000010, 16'h1111, 2'b01});
        qB.push_back('{1'b1, 24'h000020, 16'h2222, 2'b00});
        waitAck(1'b1, base + 1, 80, "tie_ackB");
        check("tie_ctl_count", 32'(ctlLog.size()), 32'd2);
        t0 = (ctlLog.size() > 0) ? ctlLog[0] : '0;
        t1 = (ctlLog.size() > 1) ? ctlLog[1] : '0;
        check("tie_first_wdata", t0.wdata, 16'h1111);
        check("tie_first_mask", t0.mask, 2'b01);
        check("tie_second_wdata", t1.wdata, 16'h2222);
        check("tie_ack_order", {ackLog.size() > 0 ? ackLog[0] : 1'b1, ackLog.size() > 1 ? ackLog[1] : 1'b0}, 2'b01);

        // continuous contention: strict alternation
        ackLog.delete();
        base = ackCntB;
        for (int i = 0; i < 3; i++) begin
            qA.push_back('{1'($urandom_range(0, 1)), 24'(24'h100000 + i), 16'(16'hA000 + i), 2'b00});
            qB.push_back('{1'($urandom_range(0, 1)), 24'(24'h200000 + i), 16'(16'hB000 + i), 2'b10});
        end
        waitAck(1'b1, base + 3, 250, "cont_ackB");
        check("cont_ack_count", 32'(ackLog.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("cont_grant_%0d", i), (i < ackLog.size()) ? ackLog[i] : ~expSeq[i], expSeq[i]);
        end

        // delayed accept with AddrA changed during ISSUE
        ctlHold = 40;
        base = ackCntA;
        qA.push_back('{1'b0, 24'h00F00D, 16'h0000, 2'b00});
        cyc(12);
        AddrA = 24'hFFFFFF;
        cyc(20);
        check("delay_ExtReq_held", ExtReq, 1'b1);
        check("delay_ExtAddr_stable", ExtAddr, 24'h00F00D);
        waitAck(1'b0, base + 1, 120, "delay_ackA");
        t0 = ctlLog[$];
        check("delay_ctl_addr", t0.addr, 24'h00F00D);

        // reset during WAIT
        ctlRdVal = 16'h5A5A;
        base = ackCntA;
        qA.push_back('{1'b0, 24'h000777, 16'h0000, 2'b00});
        n = 0;
        while (ctlBusy == 0 && n < 60) begin cyc(1); n++; end
        check("midrst_ctl_accepted", 32'(ctlBusy > 0), 32'd1);
        cyc(2);
        nReset = 1'b0;
        #1;
        check("midrst_ExtReq", ExtReq, 1'b0);
        check("midrst_Busy", Busy, 1'b0);
        cyc(3);
        nReset = 1'b1;
        cyc(1);
        ctlRdVal = 16'hC0DE;
        n = ackCntB;
        qB.push_back('{1'b0, 24'h000999, 16'h0000, 2'b00});
        waitAck(1'b1, n + 1, 80, "midrst_ackB");
        cyc(2);
        check("midrst_no_ackA", 32'(ackCntA), 32'(base));
        check("midrst_RDataB", RDataB, 16'hC0DE);
        check("midrst_RDataA_cleared", RDataA, 16'h0000);

        // randomized traffic checked by the model each cycle
        base = ackCntA + ackCntB;
        ctlRandRd = 1'b1; randEn = 1'b1;
        cyc(900);
        randEn = 1'b0;
        n = 0;
        while ((qA.size() > 0 || qB.size() > 0 || Busy) && n < 300) begin cyc(1); n++; end
        check("rand_drained", 32'(qA.size() + qB.size()), 32'd0);
        check("rand_activity", 32'((ackCntA + ackCntB - base) > 20), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
